misao_mem_arbiter: RTL

- Sole owner of the single 8-bit/15-bit-address memory port; shares it between the misao core and a host/loader port (debug, DMA, boot image).
- Sequences bring-up: holds the core in reset while the host writes the program image, then releases it.
- At runtime the core has absolute priority because it has no wait input. Host accesses are slotted into cycles where the core is not accessing memory.

---
 rtl/misao_pkg.sv | 13 +
 rtl/misao_starve_cnt.sv | 37 +++
 rtl/misao_mem_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/misao_pkg.sv
// Shared types and default widths for the misao memory arbiter slice.
package misao_pkg;

    typedef enum logic [0:0] {
        ARB_BOOT,
        ARB_RUN
    } arb_state_t;

    localparam int unsigned MISAO_ADDR_W     = 15;
    localparam int unsigned MISAO_DATA_W     = 8;
    localparam int unsigned MISAO_STARVE_MAX = 64;

endpackage

// File: rtl/misao_starve_cnt.sv
// Saturating wait counter; at_max is registered alongside the count.
module misao_starve_cnt #(
    parameter int unsigned MAX = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int unsigned CNT_W = $clog2(MAX + 1);
    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != MAX_VAL)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            at_max  <= 1'b0;
        end else begin
            count_q <= count_d;
            at_max  <= (count_d == MAX_VAL);
        end
    end

endmodule

// File: rtl/misao_mem_arbiter.sv
// Single-port memory arbiter: core has zero-latency absolute priority, host fills idle cycles,
// and a BOOT/RUN sequencer holds the core in reset while the host loads the image.
module misao_mem_arbiter
    import misao_pkg::*;
#(
    parameter int unsigned ADDR_W        = MISAO_ADDR_W,
    parameter int unsigned DATA_W        = MISAO_DATA_W,
    parameter int unsigned STARVE_MAX    = MISAO_STARVE_MAX,
    parameter bit          BOOT_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              cpu_rst,
    input  logic              cpu_enable_read,
    input  logic              cpu_enable_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data_out,
    output logic [DATA_W-1:0] cpu_data_in,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              boot_done,
    input  logic              boot_enter,
    output logic              host_starve,
    output logic              mem_enable_read,
    output logic              mem_enable_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_out,
    input  logic [DATA_W-1:0] mem_data_in
);

    localparam arb_state_t RESET_STATE = BOOT_ON_RESET ? ARB_BOOT : ARB_RUN;

    arb_state_t state;
    logic       core_access;
    logic       grant;
    logic       starve_inc;

    // Core strobes only count in RUN; in BOOT the core is held in reset.
    assign core_access = (state == ARB_RUN) && (cpu_enable_read || cpu_enable_write);
    // ~host_ack keeps a still-asserted request from being granted twice.
    assign grant       = host_req && !host_ack && !core_access;
    assign starve_inc  = host_req && !grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RESET_STATE;
            cpu_rst    <= BOOT_ON_RESET;
            host_ack   <= 1'b0;
            host_rdata <= '0;
        end else begin
            host_ack <= grant;
            if (grant && !host_we) begin
                host_rdata <= mem_data_in;
            end
            unique case (state)
                ARB_BOOT: if (boot_done && !boot_enter) state <= ARB_RUN;
                ARB_RUN:  if (boot_enter && !boot_done) state <= ARB_BOOT;
            endcase
            // Stays high through the first RUN cycle after leaving BOOT.
            cpu_rst <= (state == ARB_BOOT) || (boot_enter && !boot_done);
        end
    end

    always_comb begin
        mem_enable_read  = 1'b0;
        mem_enable_write = 1'b0;
        mem_addr         = '0;
        mem_data_out     = '0;
        cpu_data_in      = '0;
        if (core_access) begin
            mem_enable_read  = cpu_enable_read;
            mem_enable_write = cpu_enable_write;
            mem_addr         = cpu_addr;
            mem_data_out     = cpu_data_out;
            if (cpu_enable_read) begin
                cpu_data_in = mem_data_in;
            end
        end else if (grant) begin
            mem_enable_read  = !host_we;
            mem_enable_write = host_we;
            mem_addr         = host_addr;
            mem_data_out     = host_wdata;
        end
    end

    misao_starve_cnt #(
        .MAX(STARVE_MAX)
    ) u_starve_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (starve_inc),
        .clr   (!starve_inc),
        .at_max(host_starve)
    );

endmodule
